// File: rtl/timer_nivel2.sv
// Three-digit BCD countdown timer (M:SS) with serial digit loading.
// Digits shift in from the seconds side; counting stops at 0:00.
module timer_nivel2 (
  input  logic [3:0] data,
  input  logic       enable,
  input  logic       CLK,
  input  logic       loadn,
  input  logic       clearn,
  output logic       timer_done,
  output logic [3:0] secs,
  output logic [3:0] tens_secs,
  output logic [3:0] minutes
);

  logic [3:0] r_secs;
  logic [3:0] r_tens;
  logic [3:0] r_min;

  logic [3:0] w_secs_load;
  logic [3:0] w_tens_load;
  logic       w_zero;

  // Clamp on the way in so every reachable state is a legal BCD count.
  assign w_secs_load = (data > 4'd9) ? 4'd9 : data;
  assign w_tens_load = (r_secs > 4'd5) ? 4'd5 : r_secs;
  assign w_zero      = (r_min == 4'd0) && (r_tens == 4'd0) && (r_secs == 4'd0);

  always_ff @(posedge CLK or negedge clearn) begin
    if (!clearn) begin
      r_secs <= 4'd0;
      r_tens <= 4'd0;
      r_min  <= 4'd0;
    end else if (!loadn) begin
      r_min  <= r_tens;
      r_tens <= w_tens_load;
      r_secs <= w_secs_load;
    end else if (enable && !w_zero) begin
      if (r_secs != 4'd0) begin
        r_secs <= r_secs - 4'd1;
      end else begin
        r_secs <= 4'd9;
        if (r_tens != 4'd0) begin
          r_tens <= r_tens - 4'd1;
        end else begin
          r_tens <= 4'd5;
          r_min  <= r_min - 4'd1;
        end
      end
    end
  end

  assign secs       = r_secs;
  assign tens_secs  = r_tens;
  assign minutes    = r_min;
  assign timer_done = w_zero;

endmodule

// File: tb/tb_timer_nivel2.sv
// Scoreboard bench for timer_nivel2: stimulus queues expected M:SS values,
// a monitor process pops and compares them against the DUT outputs.
module tb_timer_nivel2;

  logic [3:0] data;
  logic       enable;
  logic       CLK;
  logic       loadn;
  logic       clearn;
  logic       timer_done;
  logic [3:0] secs;
  logic [3:0] tens_secs;
  logic [3:0] minutes;

  logic clk_run;

  typedef struct {
    string      name;
    logic       done;
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] s;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  timer_nivel2 dut (
    .data       (data),
    .enable     (enable),
    .CLK        (CLK),
    .loadn      (loadn),
    .clearn     (clearn),
    .timer_done (timer_done),
    .secs       (secs),
    .tens_secs  (tens_secs),
    .minutes    (minutes)
  );

  initial CLK = 1'b0;
  always #5 CLK = clk_run ? ~CLK : 1'b0;

  // Monitor: compares as soon as an expectation is posted (outputs already settled).
  initial begin
    exp_t e;
    forever begin
      wait (exp_q.size() != 0);
      e = exp_q.pop_front();
      checks++;
      if ({timer_done, minutes, tens_secs, secs} !== {e.done, e.m, e.t, e.s}) begin
        errors++;
        $display("FAIL %s: got done=%0b %0d:%0d%0d, required done=%0b %0d:%0d%0d",
                 e.name, timer_done, minutes, tens_secs, secs, e.done, e.m, e.t, e.s);
      end else begin
        $display("ok   %s: done=%0b %0d:%0d%0d", e.name, timer_done, minutes, tens_secs, secs);
      end
    end
  end

  task automatic expect_val(input string name, input logic done,
                            input logic [3:0] m, input logic [3:0] t, input logic [3:0] s);
    exp_t e;
    e.name = name;
    e.done = done;
    e.m    = m;
    e.t    = t;
    e.s    = s;
    exp_q.push_back(e);
    #0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic load_digit(input logic [3:0] d);
    loadn = 1'b0;
    data  = d;
    tick(1);
  endtask

  initial begin
    clk_run = 1'b0;
    checks  = 0;
    errors  = 0;
    data    = 4'd0;
    enable  = 1'b0;
    loadn   = 1'b1;
    clearn  = 1'b1;

    // Asynchronous clear with no clock running
    #3 clearn = 1'b0;
    #1 expect_val("reset_noclk", 1'b1, 4'd0, 4'd0, 4'd0);
    #2 clearn = 1'b1;
    #1 expect_val("reset_release_hold", 1'b1, 4'd0, 4'd0, 4'd0);

    clk_run = 1'b1;
    #2;
    // Load 2,1,7,9 with enable high: load must win; tens 7 clamps to 5
    enable = 1'b1;
    load_digit(4'd2); expect_val("load_2", 1'b0, 4'd0, 4'd0, 4'd2);
    load_digit(4'd1); expect_val("load_21", 1'b0, 4'd0, 4'd2, 4'd1);
    load_digit(4'd7); expect_val("load_217", 1'b0, 4'd2, 4'd1, 4'd7);
    load_digit(4'd9); expect_val("load_clamp_159", 1'b0, 4'd1, 4'd5, 4'd9);

    loadn = 1'b1;
    tick(1);   expect_val("run_1", 1'b0, 4'd1, 4'd5, 4'd8);
    tick(9);   expect_val("run_10", 1'b0, 4'd1, 4'd4, 4'd9);
    tick(50);  expect_val("run_60", 1'b0, 4'd0, 4'd5, 4'd9);
    tick(58);  expect_val("run_118", 1'b0, 4'd0, 4'd0, 4'd1);
    tick(1);   expect_val("run_119_zero", 1'b1, 4'd0, 4'd0, 4'd0);
    tick(381); expect_val("run_500_hold", 1'b1, 4'd0, 4'd0, 4'd0);

    // Pause check from 5:43
    load_digit(4'd5); load_digit(4'd4); load_digit(4'd3);
    expect_val("load_543", 1'b0, 4'd5, 4'd4, 4'd3);
    loadn = 1'b1;
    tick(3); expect_val("run_540", 1'b0, 4'd5, 4'd4, 4'd0);
    enable = 1'b0;
    tick(5); expect_val("pause_hold", 1'b0, 4'd5, 4'd4, 4'd0);
    enable = 1'b1;
    tick(1);  expect_val("resume_539", 1'b0, 4'd5, 4'd3, 4'd9);
    tick(40); expect_val("run_459", 1'b0, 4'd4, 4'd5, 4'd9);

    // Data 15 clamps to 9; secs 9 shifting into tens clamps to 5
    load_digit(4'd15); expect_val("data_clamp_15", 1'b0, 4'd5, 4'd5, 4'd9);
    load_digit(4'd10); expect_val("data_clamp_10", 1'b0, 4'd5, 4'd5, 4'd9);

    // Clear mid-count, between clock edges
    loadn = 1'b1;
    tick(7); expect_val("run_552", 1'b0, 4'd5, 4'd5, 4'd2);
    #2 clearn = 1'b0;
    #1 expect_val("clear_midcount", 1'b1, 4'd0, 4'd0, 4'd0);
    data  = 4'd7;
    loadn = 1'b0;
    tick(2); expect_val("clear_overrides_load", 1'b1, 4'd0, 4'd0, 4'd0);
    clearn = 1'b1;
    load_digit(4'd3); load_digit(4'd0);
    expect_val("reload_030", 1'b0, 4'd0, 4'd3, 4'd0);
    loadn = 1'b1;
    tick(1);  expect_val("run_029", 1'b0, 4'd0, 4'd2, 4'd9);
    tick(29); expect_val("run_030_zero", 1'b1, 4'd0, 4'd0, 4'd0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
